// File: rtl/pulse_sequencer.sv
// pulse_sequencer: pre-blank/P1/P2-train sequencer with period-boundary shadowing; PULSE_SEQ_PHASE_CYCLE_EN adds a phase output
module pulse_sequencer #(
  parameter int unsigned MIN_PERIOD = 2,
  parameter int CP_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pu,
  input  logic [31:0]     per,
  input  logic [31:0]     p1wid,
  input  logic [31:0]     del,
  input  logic [31:0]     p2wid,
  input  logic [CP_W-1:0] cp,
  input  logic [7:0]      p_bl,
  input  logic [15:0]     p_bl_off,
  input  logic            bl,
  output logic            pulse,
  output logic            inhib,
  output logic            sync,
  output logic            busy,
  output logic [CP_W-1:0] echo_idx
`ifdef PULSE_SEQ_PHASE_CYCLE_EN
  ,
  output logic [1:0]      phase
`endif
);
  typedef enum logic [2:0] {IDLE, PRE, P1, GAP1, P2, GAPN, HOLD} state_t;
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
  localparam logic [CP_W-1:0] ONE = CP_W'(1);
  state_t st, st_n, e;
  logic [31:0] pcnt, pcnt_n, per_s, per_r, w1_r, d_r, w2_r, nw1, nd, nw2;
  logic [CP_W-1:0] n_r, nn, k_n, kk;
  logic [7:0] a_r, na;
  logic [15:0] off_r, noff;
  logic pu_r, bl_r, npu, nbl, wrap, ent;
  logic [32:0] cnt, cnt_n;
  assign per_s = per_r < MIN_P ? MIN_P : per_r;
  assign wrap = pcnt >= per_s - 32'd1;
  assign pcnt_n = wrap ? '0 : pcnt + 32'd1;
  // everything below is evaluated for the next cycle, so a wrap sees the freshly latched inputs
  assign {nw1, nd, nw2, nn, na, noff, npu, nbl} = wrap ?
    {p1wid, del, p2wid, cp, p_bl, p_bl_off, pu, bl} :
    {w1_r, d_r, w2_r, n_r, a_r, off_r, pu_r, bl_r};
  always_comb begin
    st_n = st;
    cnt_n = cnt - 33'd1;
    k_n = echo_idx;
    kk = echo_idx;
    e = st;
    ent = 1'b0;
    if (wrap) begin
      ent = 1'b1;
      e = PRE;
      kk = '0;
    end else if (st != IDLE && cnt <= 33'd1) begin
      ent = 1'b1;
      e = st == PRE ? P1 : st == P1 ? (nn == '0 ? HOLD : GAP1) : st == GAP1 ? P2 :
          st == P2 ? (echo_idx < nn - ONE ? GAPN : HOLD) : st == GAPN ? P2 : IDLE;
      kk = st == GAPN ? echo_idx + ONE : echo_idx;
    end
    // zero-length states fall through within the same cycle; an all-zero P2/GAPN loop collapses to the last echo
    if (ent && e == PRE && na == '0) e = P1;
    if (ent && e == P1 && nw1 == '0) e = nn == '0 ? HOLD : GAP1;
    if (ent && e == GAP1 && nd == '0) e = P2;
    if (ent && e == P2 && nw2 == '0 && nd == '0) begin
      e = HOLD;
      kk = nn - ONE;
    end
    if (ent && e == P2 && nw2 == '0) e = kk < nn - ONE ? GAPN : HOLD;
    if (ent && e == GAPN && nd == '0) begin
      e = P2;
      kk = kk + ONE;
    end
    if (ent && e == HOLD && noff == '0) e = IDLE;
    if (ent) begin
      st_n = e;
      k_n = kk;
      cnt_n = e == PRE ? 33'(na) : e == P1 ? 33'(nw1) : e == GAP1 ? 33'(nd) :
              e == P2 ? 33'(nw2) : e == GAPN ? {nd, 1'b0} : e == HOLD ? 33'(noff) : '0;
    end else if (st == IDLE) cnt_n = '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt <= '0;
      st <= IDLE;
      cnt <= '0;
      {per_r, w1_r, d_r, w2_r, n_r, a_r, off_r, pu_r, bl_r} <= '0;
      {pulse, inhib, sync, busy} <= '0;
      echo_idx <= '0;
    end else begin
      pcnt <= pcnt_n;
      st <= st_n;
      cnt <= cnt_n;
      if (wrap) {per_r, w1_r, d_r, w2_r, n_r, a_r, off_r, pu_r, bl_r} <=
        {per, p1wid, del, p2wid, cp, p_bl, p_bl_off, pu, bl};
      pulse <= npu && (st_n == P1 || st_n == P2);
      inhib <= nbl && st_n != IDLE;
      sync <= pcnt_n == '0;
      busy <= st_n != IDLE;
      echo_idx <= k_n;
    end
  end
`ifdef PULSE_SEQ_PHASE_CYCLE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) phase <= '0;
    else if (wrap) phase <= phase + 2'd1;
  end
`endif
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Turns the pulse-parameter registers written over the serial link into the physical pulse train on every repetition period.
- Fires a pre-blank window, pulse 1, then cp refocusing pulses (Hahn echo / CPMG spacing).
- Produces a receiver-inhibit window.
- Captures new parameters into shadow registers only at period boundaries, so a serial write never tears a sequence in progress.

Parameters:
- MIN_PERIOD, 2, floor applied to the latched period (cycles).
- CP_W, 8, width of the echo-count input.

Ports:
- clk  in  1  system pulse clock.
- resetn  in  1  asynchronous active-low reset.
- pu  in  1  pump enable; 0 suppresses pulse output only.
- per  in  32  period, cycles.
- p1wid  in  32  pulse-1 width, cycles.
- del  in  32  pulse-1-end to first-pulse-2 delay, cycles.
- p2wid  in  32  pulse-2 width, cycles.
- cp  in  CP_W  number of pulse-2 repetitions (0 = pulse 1 only).
- p_bl  in  8  pre-blank cycles before pulse 1.
- p_bl_off  in  16  inhibit hold-off after the last pulse, cycles.
- bl  in  1  inhibit enable.
- pulse  out  1  combined pulse drive.
- inhib  out  1  receiver blanking.
- sync  out  1  one-cycle strobe at period start.
- busy  out  1  sequence active (state != IDLE).
- echo_idx  out  CP_W  index of the current or last pulse 2.

Behaviour:
- Reset: all outputs 0. pcnt = 0. All shadows = 0. state = IDLE.
- Period counter pcnt (32b): increments each cycle; wraps to 0 when pcnt >= per_s-1.
- per_s = max(latched per, MIN_PERIOD), so the first period after reset is 2 cycles with no pulses.
- Shadow load: on the cycle pcnt wraps, all inputs (per..bl, pu) are latched. Input changes at any other time have no effect until the next wrap.
- Timing: all outputs are registered. The values below are the output level in the cycle whose pcnt register holds the stated value. Let a=p_bl, w1=p1wid, d=del, w2=p2wid, n=cp (shadowed).
- sync = 1 iff pcnt==0.
- P1 spans pcnt in [a, a+w1).
- P2 number k (0..n-1) spans [s_k, s_k+w2), where s_k = a+w1+d+k*(2d+w2). Compute in 33b or wider and saturate; no wrap-around.
- pulse = pu_s AND (in P1 or any P2).
- E = a+w1 if n=0, else s_(n-1)+w2.
- inhib = bl_s AND pcnt in [0, E+p_bl_off).
- echo_idx = k while in P2 number k or in the gap after it; 0 before the first P2.
- FSM states: IDLE, PRE, P1, GAP1, P2, GAPN, HOLD.
  - pcnt wrap -> PRE; if a=0, go directly to P1.
  - PRE ends after a cycles -> P1.
  - P1 ends after w1 cycles -> GAP1 (if n=0 -> HOLD).
  - GAP1 ends after d cycles -> P2.
  - P2 ends after w2 cycles -> GAPN (2d cycles) -> P2 while k < n-1; otherwise -> HOLD.
  - HOLD ends after p_bl_off cycles -> IDLE.
- Zero-length states are skipped in the same cycle. Skipping never shifts later edges.
- Truncation: if the sequence is longer than per_s, pcnt wrap aborts it. FSM goes to PRE, echo_idx resets, and pulse/inhib follow the new period's timeline. There is no carry-over.
- pu_s=0: FSM, sync and inhib run normally; pulse stays 0.
- Reset asserted mid-sequence: pulse and inhib drop asynchronously to 0.

Optional Feature:
- Macro PULSE_SEQ_PHASE_CYCLE_EN.
- When defined: adds output phase[1:0], reset 0, incremented (mod 4) on every wrap. It is registered and valid for the whole period, for the downstream phase-cycling mux.
- When undefined: port absent, no extra logic.

Test Plan:
- Basic echo: per=100, p_bl=5, p1wid=3, del=10, p2wid=6, cp=1, bl=1, p_bl_off=4, pu=1 -> pulse at pcnt 5-7 and 18-23; inhib at 0-27; sync at 0; echo_idx=0.
- CPMG: same values with cp=3 -> P2 at pcnt 18-23, 44-49, 70-75; echo_idx 0,1,2; inhib ends after pcnt 79.
- Shadowing: change del to 20 at pcnt=30 -> current period unchanged; next period's P2 starts at pcnt 28.
- Truncation: per=40 with the CPMG settings -> P2 only at pcnt 18-23; second P2 cut; next period restarts cleanly at pcnt 0 with sync.
- Edge/zero cases:
  - cp=0 -> P1 only.
  - p_bl=0 -> P1 starts at pcnt 0.
  - pu=0 -> pulse always 0, inhib unchanged.
  - per=0 -> 2-cycle period.
- Reset: pull resetn low at pcnt 20 -> all outputs 0 immediately. After release, first period is 2 cycles, then the programmed period starts.
